// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: round-robin arbitration of ALU (A) and load (B) results onto the single
// register file write port, plus a pending-write scoreboard. Optional macro: REGFILE_WB_BYPASS_EN.
module regfile_wb_ctrl #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  input  logic [4:0]      a_rd,
  input  logic [XLEN-1:0] a_data,
  output logic            a_ready,
  input  logic            b_valid,
  input  logic [4:0]      b_rd,
  input  logic [XLEN-1:0] b_data,
  output logic            b_ready,
  output logic            write_enable,
  output logic [4:0]      write_reg,
  output logic [XLEN-1:0] write_data,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            issue_stall
);

  logic             last_grant_q, last_grant_d;
  logic             write_enable_q, write_enable_d;
  logic [4:0]       write_reg_q, write_reg_d;
  logic [XLEN-1:0]  write_data_q, write_data_d;
  logic [NREGS-1:0] busy_q, busy_d;

  logic             grant_a, grant_b, xfer, xfer_wr;
  logic [4:0]       xfer_rd;
  logic [XLEN-1:0]  xfer_data;

  // Nothing is granted while reset is held so no transfer can be lost.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (rst) begin
      if (a_valid && b_valid) begin
        grant_a = last_grant_q;
        grant_b = ~last_grant_q;
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  assign a_ready   = grant_a;
  assign b_ready   = grant_b;
  assign xfer      = grant_a | grant_b;
  assign xfer_rd   = grant_a ? a_rd : b_rd;
  assign xfer_data = grant_a ? a_data : b_data;
  assign xfer_wr   = xfer && (xfer_rd != 5'd0);

  always_comb begin
    last_grant_d   = last_grant_q;
    write_enable_d = xfer_wr;
    write_reg_d    = write_reg_q;
    write_data_d   = write_data_q;
    busy_d         = busy_q;
    if (xfer) begin
      last_grant_d = grant_b;
    end
    if (xfer_wr) begin
      write_reg_d       = xfer_rd;
      write_data_d      = xfer_data;
      busy_d[xfer_rd]   = 1'b0;
    end
    // Applied after the clear: a newly issued write to the same rd is still pending.
    if (issue_valid && (issue_rd != 5'd0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q   <= 1'b1;
      write_enable_q <= 1'b0;
      write_reg_q    <= 5'd0;
      write_data_q   <= '0;
      busy_q         <= '0;
    end else begin
      last_grant_q   <= last_grant_d;
      write_enable_q <= write_enable_d;
      write_reg_q    <= write_reg_d;
      write_data_q   <= write_data_d;
      busy_q         <= busy_d;
    end
  end

  assign write_enable = write_enable_q;
  assign write_reg    = write_reg_q;
  assign write_data   = write_data_q;

`ifdef REGFILE_WB_BYPASS_EN
  // A register written back this cycle can be forwarded from write_data next cycle.
  assign rs1_busy = busy_q[rs1] && !(xfer_wr && (xfer_rd == rs1));
  assign rs2_busy = busy_q[rs2] && !(xfer_wr && (xfer_rd == rs2));
`else
  assign rs1_busy = busy_q[rs1];
  assign rs2_busy = busy_q[rs2];
`endif

  assign issue_stall = issue_valid && (rs1_busy || rs2_busy || busy_q[issue_rd]);

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: directed cases plus randomized traffic against a
// behavioural model of arbitration, write port and scoreboard.
module tb_regfile_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, issue_valid;
  logic [4:0]  a_rd, b_rd, issue_rd, rs1, rs2;
  logic [63:0] a_data, b_data;
  logic        a_ready, b_ready, write_enable, rs1_busy, rs2_busy, issue_stall;
  logic [4:0]  write_reg;
  logic [63:0] write_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_wb_ctrl #(.XLEN(64), .NREGS(32)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .write_enable(write_enable), .write_reg(write_reg), .write_data(write_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .issue_stall(issue_stall)
  );

  // Model state
  bit          m_busy [32];
  bit          m_b_last;
  bit          m_we;
  logic [4:0]  m_wreg;
  logic [63:0] m_wdata;
  // Model combinational view for the current inputs
  bit          m_ga, m_gb, m_rs1b, m_rs2b, m_stall;
  logic [4:0]  m_rd;
  logic [63:0] m_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 0;
    m_b_last = 1;
    m_we     = 0;
    m_wreg   = 0;
    m_wdata  = 0;
  endtask

  task automatic model_eval();
    bit wr;
    m_ga = 0;
    m_gb = 0;
    if (rst === 1'b1) begin
      if (a_valid && b_valid) begin
        if (m_b_last) m_ga = 1; else m_gb = 1;
      end else begin
        m_ga = a_valid;
        m_gb = b_valid;
      end
    end
    m_rd   = m_ga ? a_rd : b_rd;
    m_data = m_ga ? a_data : b_data;
    wr     = (m_ga || m_gb) && m_rd != 0;
    m_rs1b = m_busy[rs1];
    m_rs2b = m_busy[rs2];
`ifdef REGFILE_WB_BYPASS_EN
    if (wr && m_rd == rs1) m_rs1b = 0;
    if (wr && m_rd == rs2) m_rs2b = 0;
`endif
    m_stall = issue_valid && (m_rs1b || m_rs2b || m_busy[issue_rd]);
  endtask

  task automatic compare();
    model_eval();
    chk("a_ready", a_ready, m_ga);
    chk("b_ready", b_ready, m_gb);
    chk("write_enable", write_enable, m_we);
    if (m_we) begin
      chk("write_reg", write_reg, m_wreg);
      chk("write_data", write_data, m_wdata);
    end
    chk("rs1_busy", rs1_busy, m_rs1b);
    chk("rs2_busy", rs2_busy, m_rs2b);
    chk("issue_stall", issue_stall, m_stall);
  endtask

  task automatic model_step();
    model_eval();
    if (rst !== 1'b1) begin
      model_reset();
      return;
    end
    m_we = (m_ga || m_gb) && m_rd != 0;
    if (m_ga || m_gb) m_b_last = m_gb;
    if (m_we) begin
      m_wreg  = m_rd;
      m_wdata = m_data;
      m_busy[m_rd] = 0;
    end
    if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1;
  endtask

  // Inputs are set at posedge+1; compare mid-cycle, advance model, then cross the edge.
  task automatic cycle();
    #1;
    compare();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 0; b_valid = 0; issue_valid = 0;
    a_rd = 0; b_rd = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
    a_data = 0; b_data = 0;
  endtask

  bit a_hold, b_hold;

  initial begin
    idle_inputs();
    rst = 0;
    model_reset();
    // Reset: A requesting while reset held
    a_valid = 1; a_rd = 5'd3; a_data = 64'h1234_5678_9abc_def0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_write_enable", write_enable, 0);
    chk("rst_write_reg", write_reg, 0);
    chk("rst_write_data", write_data, 0);
    for (int r = 0; r < 32; r++) begin
      rs1 = r[4:0];
      #1;
      chk("rst_busy", rs1_busy, 0);
    end
    rs1 = 0;
    cycle();
    rst = 1;
    #1;
    chk("release_a_ready", a_ready, 1);
    cycle();
    chk("release_we", write_enable, 1);
    chk("release_reg", write_reg, 3);
    chk("release_data", write_data, 64'h1234_5678_9abc_def0);

    // Reset mid-flight: transfer rd=4 while issuing rd=8, then async reset
    idle_inputs();
    a_valid = 1; a_rd = 5'd4; a_data = 64'h44; issue_valid = 1; issue_rd = 5'd8;
    cycle();
    idle_inputs();
    rs1 = 5'd8;
    #1;
    chk("mid_we_before", write_enable, 1);
    chk("mid_busy_before", rs1_busy, 1);
    rst = 0;
    #1;
    chk("mid_we_after", write_enable, 0);
    chk("mid_busy_after", rs1_busy, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1;
    cycle();

    // Contention: grants A,B,A,B
    a_valid = 1; b_valid = 1; a_rd = 5'd5; b_rd = 5'd6; a_data = 64'hA5; b_data = 64'hB6;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("contend_a_ready", a_ready, (k % 2 == 0));
      cycle();
      chk("contend_write_reg", write_reg, (k % 2 == 0) ? 5 : 6);
    end
    idle_inputs();

    // x0 drop on port B
    b_valid = 1; b_rd = 5'd0; b_data = 64'hDEAD;
    #1;
    chk("x0_b_ready", b_ready, 1);
    cycle();
    chk("x0_write_enable", write_enable, 0);
    idle_inputs();

    // Scoreboard on x7
    issue_valid = 1; issue_rd = 5'd7;
    cycle();
    issue_valid = 0; rs1 = 5'd7;
    #1;
    chk("sb_rs1_busy", rs1_busy, 1);
    issue_valid = 1;
    #1;
    chk("sb_issue_stall", issue_stall, 1);
    cycle();
    issue_valid = 0; a_valid = 1; a_rd = 5'd7; a_data = 64'h77;
    #1;
`ifdef REGFILE_WB_BYPASS_EN
    chk("sb_clear_same", rs1_busy, 0);
`else
    chk("sb_clear_same", rs1_busy, 1);
`endif
    cycle();
    a_valid = 0;
    #1;
    chk("sb_clear_next", rs1_busy, 0);
    idle_inputs();

    // Set/clear collision on x9
    issue_valid = 1; issue_rd = 5'd9; a_valid = 1; a_rd = 5'd9; a_data = 64'h99;
    cycle();
    idle_inputs();
    rs2 = 5'd9;
    #1;
    chk("collide_busy", rs2_busy, 1);
    cycle();

    // Randomized traffic; requesters hold rd/data while waiting
    a_hold = 0;
    b_hold = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!a_hold) begin
        a_valid = ($urandom_range(0, 3) != 0);
        a_rd    = 5'($urandom_range(0, 11));
        a_data  = {$urandom, $urandom};
      end
      if (!b_hold) begin
        b_valid = ($urandom_range(0, 2) != 0);
        b_rd    = 5'($urandom_range(0, 11));
        b_data  = {$urandom, $urandom};
      end
      issue_valid = ($urandom_range(0, 1) != 0);
      issue_rd    = 5'($urandom_range(0, 11));
      rs1         = 5'($urandom_range(0, 11));
      rs2         = 5'($urandom_range(0, 31));
      #1;
      model_eval();
      a_hold = a_valid && !m_ga;
      b_hold = b_valid && !m_gb;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
